// File: rtl/act_lane_pipe_pkg.sv
// Shared constants for the activation lane pipeline: default lane width,
// activation mode encodings and source-select values.
package act_lane_pipe_pkg;

  localparam int unsigned ACT_DATA_W = 16;

  typedef enum logic [1:0] {
    ACT_MODE_IDENT = 2'd0,
    ACT_MODE_RELU  = 2'd1,
    ACT_MODE_CLIP  = 2'd2,
    ACT_MODE_LEAKY = 2'd3
  } act_mode_e;

  localparam logic ACT_SRC_IN0 = 1'b0;
  localparam logic ACT_SRC_IN1 = 1'b1;

endpackage

// File: rtl/act_lane_pipe_if.sv
// Beat-level valid/ready bus of the activation pipeline: two pre-activation
// sources in, activated lanes out.
interface act_lane_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in0;
  logic [LANES*DATA_W-1:0]   in1;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in0, in1, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in0, in1, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/act_lane_pipe_fn.sv
// Combinational single-lane activation function (act_lane_fn).
// Leaky ReLU in mode 3 only with ACT_LEAKY_EN defined; otherwise mode 3 is ReLU.
module act_lane_fn
  import act_lane_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = ACT_DATA_W,
  parameter int unsigned LEAKY_SH = 3
) (
  input  logic signed [DATA_W-1:0] x,
  input  act_mode_e                mode,
  input  logic        [DATA_W-1:0] clip,
  output logic signed [DATA_W-1:0] y
);

  always_comb begin
    y = x;
    case (mode)
      ACT_MODE_IDENT: y = x;
      ACT_MODE_RELU: begin
        if (x < 0) y = '0;
      end
      ACT_MODE_CLIP: begin
        // x is non-negative here, so an unsigned compare against clip is exact
        if (x < 0) y = '0;
        else if ($unsigned(x) > clip) y = $signed(clip);
      end
      ACT_MODE_LEAKY: begin
`ifdef ACT_LEAKY_EN
        if (x < 0) y = x >>> LEAKY_SH;
`else
        if (x < 0) y = '0;
`endif
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_lane_pipe.sv
// Two-stage valid/ready activation stage with per-beat captured config and a
// saturating zero-lane counter. Optional feature macro: ACT_LEAKY_EN.
module act_lane_pipe
  import act_lane_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = ACT_DATA_W,
  parameter int unsigned LANES    = 4,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned LEAKY_SH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_src,
  input  logic [DATA_W-1:0] cfg_clip,
  act_lane_pipe_if.slave    bus,
  output logic [CNT_W-1:0]  zero_cnt
);

  localparam int unsigned W  = LANES * DATA_W;
  localparam int unsigned ZW = $clog2(LANES + 1);
  localparam logic [DATA_W-1:0] CLIP_RST = {1'b0, {(DATA_W-1){1'b1}}};

  act_mode_e         cfg_mode_q, s1_mode;
  logic              cfg_src_q;
  logic [DATA_W-1:0] cfg_clip_q, s1_clip;
  logic              s1_v, s2_v, s1_adv, s2_adv;
  logic [W-1:0]      s1_x, s2_y, fn_y;
  logic [ZW-1:0]     zeros;
  logic [CNT_W:0]    cnt_sum;

  assign s2_adv        = !s2_v || bus.out_ready;
  assign s1_adv        = !s1_v || s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_mode_q <= ACT_MODE_RELU;
      cfg_src_q  <= ACT_SRC_IN0;
      cfg_clip_q <= CLIP_RST;
    end else if (cfg_we) begin
      cfg_mode_q <= act_mode_e'(cfg_mode);
      cfg_src_q  <= cfg_src;
      cfg_clip_q <= cfg_clip;
    end
  end

  // Config travels with the beat, so later cfg writes never touch beats in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_x    <= '0;
      s1_mode <= ACT_MODE_RELU;
      s1_clip <= CLIP_RST;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x    <= (cfg_src_q == ACT_SRC_IN1) ? bus.in1 : bus.in0;
        s1_mode <= cfg_mode_q;
        s1_clip <= cfg_clip_q;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane_fn #(
      .DATA_W  (DATA_W),
      .LEAKY_SH(LEAKY_SH)
    ) u_fn (
      .x   (s1_x[i*DATA_W +: DATA_W]),
      .mode(s1_mode),
      .clip(s1_clip),
      .y   (fn_y[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      s2_y <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) s2_y <= fn_y;
    end
  end

  always_comb begin
    zeros = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (s2_y[i*DATA_W +: DATA_W] == '0) zeros = zeros + ZW'(1);
    end
    cnt_sum = {1'b0, zero_cnt} + (CNT_W+1)'(zeros);
  end

  // A config write clears the count even when an output handshake coincides
  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      zero_cnt <= '0;
    end else if (s2_v && bus.out_ready) begin
      zero_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_lane_pipe.sv
// Scoreboard bench for act_lane_pipe: directed beats push expected outputs,
// a negedge monitor pops and compares on every output handshake.
module tb_act_lane_pipe;
  import act_lane_pipe_pkg::*;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int CW = 4;
  typedef logic [L*DW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_mode = 2'd1;
  logic          cfg_src = 1'b0;
  logic [DW-1:0] cfg_clip = 16'h7fff;
  logic [CW-1:0] zero_cnt;

  act_lane_pipe_if #(.DATA_W(DW), .LANES(L)) bus ();

  act_lane_pipe #(
    .DATA_W  (DW),
    .LANES   (L),
    .CNT_W   (CW),
    .LEAKY_SH(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_mode(cfg_mode),
    .cfg_src (cfg_src),
    .cfg_clip(cfg_clip),
    .bus     (bus),
    .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  int    rx = 0;
  int    rx_base = 0;
  int    gaps = 0;
  logic  stream_on = 1'b0;
  logic  saw_full = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic beat_t pack4(input int a, input int b, input int c, input int d);
    beat_t r;
    r[0*DW +: DW] = a[DW-1:0];
    r[1*DW +: DW] = b[DW-1:0];
    r[2*DW +: DW] = c[DW-1:0];
    r[3*DW +: DW] = d[DW-1:0];
    return r;
  endfunction

  // Monitor: scoreboard pop, hold-while-stalled and streaming-rate checks
  initial begin
    logic  stall_prev;
    beat_t data_prev;
    beat_t e;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, data_prev);
        end
        if (stream_on && bus.in_valid && !bus.in_ready) saw_full = 1'b1;
        if (stream_on && bus.out_ready && !bus.out_valid && rx > rx_base && rx < rx_base + 10)
          gaps++;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h expected=none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e);
            rx++;
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        data_prev  = bus.out_data;
      end
    end
  end

  task automatic send(input beat_t a, input beat_t b, input beat_t e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in0 = a;
    bus.in1 = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic cfg(input logic [1:0] m, input logic s, input logic [DW-1:0] c);
    cfg_mode = m;
    cfg_src  = s;
    cfg_clip = c;
    cfg_we   = 1'b1;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t leaky_exp;
    int    leaky_zc;
    bus.in_valid  = 1'b0;
    bus.in0       = '0;
    bus.in1       = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_zero_cnt", zero_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);

    // ReLU from reset config, source 0, with latency probe
    send(pack4(-5, 0, 7, -32768), pack4(1, 1, 1, 1), pack4(0, 0, 7, 0));
    check("lat_not_yet", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", bus.out_valid, 1);
    drain();
    check("zc_relu", zero_cnt, 3);

    // Clipped ReLU from source 1
    cfg(2'd2, 1'b1, 16'd100);
    check("zc_cfg_clear", zero_cnt, 0);
    send(pack4(1, 2, 3, 4), pack4(250, -1, 100, 99), pack4(100, 0, 100, 99));
    drain();
    check("zc_clip", zero_cnt, 1);

    // Mode 3
`ifdef ACT_LEAKY_EN
    leaky_exp = pack4(-2, -1, 8, 0);
    leaky_zc  = 1;
`else
    leaky_exp = pack4(0, 0, 8, 0);
    leaky_zc  = 3;
`endif
    cfg(2'd3, 1'b0, 16'd100);
    send(pack4(-16, -1, 8, 0), pack4(5, 5, 5, 5), leaky_exp);
    drain();
    check("zc_mode3", zero_cnt, leaky_zc);

    // Ten-beat stream with out_ready low for cycles 3..6
    cfg(2'd0, 1'b0, 16'h7fff);
    rx_base   = rx;
    gaps      = 0;
    saw_full  = 1'b0;
    stream_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          beat_t v;
          v = pack4((k+1)*10, (k+1)*10+1, -((k+1)*10+2), (k+1)*10+3);
          send(v, '0, v);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    stream_on = 1'b0;
    check("stream_count", rx - rx_base, 10);
    check("stream_full", saw_full, 1);
    check("stream_gaps", gaps, 0);
    check("zc_stream", zero_cnt, 0);

    // Config write coincident with accept: that beat keeps the old ReLU mode
    cfg(2'd1, 1'b0, 16'h7fff);
    cfg_mode = 2'd0;
    cfg_src  = 1'b0;
    cfg_we   = 1'b1;
    send(pack4(-3, 5, 0, -7), '0, pack4(0, 5, 0, 0));
    cfg_we = 1'b0;
    send(pack4(-3, 5, 0, -7), '0, pack4(-3, 5, 0, -7));
    @(posedge clk); #1;
    check("zc_before_clear", zero_cnt, 3);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("zc_clear_wins", zero_cnt, 0);
    check("cfg_beat_done", bus.out_valid, 0);

    // Reset with two beats in flight
    send(pack4(0, 0, 0, 0), '0, pack4(0, 0, 0, 0));
    drain();
    check("zc_all_zero", zero_cnt, 4);
    bus.out_ready = 1'b0;
    send(pack4(11, 12, 13, 14), '0, pack4(11, 12, 13, 14));
    send(pack4(21, 22, 23, 24), '0, pack4(21, 22, 23, 24));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data", bus.out_data, 0);
    check("midrst_zc", zero_cnt, 0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_leak", bus.out_valid, 0);
    send(pack4(-9, 0, 4, -1), '0, pack4(0, 0, 4, 0));
    drain();
    check("zc_relu_after_rst", zero_cnt, 3);

    // Saturation at 2^CW-1
    for (int k = 0; k < 3; k++) send(pack4(0, 0, 0, 0), '0, pack4(0, 0, 0, 0));
    drain();
    check("zc_at_max", zero_cnt, 15);
    send(pack4(0, 0, 0, 0), '0, pack4(0, 0, 0, 0));
    drain();
    check("zc_saturate", zero_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
